// File: rtl/rv_fetch_pkg.sv
// Shared definitions for the instruction prefetch front-end.
//   DEFAULT_NOP_INST : word presented downstream when nothing is buffered
//   DEFAULT_RESET_PC : first fetch address after reset
//   PC_INC           : sequential fetch stride in bytes
//   PC_ALIGN_MASK    : clears the byte-offset bits of a redirect target
//   fetch_state_t    : front-end FSM states
//   fetch_entry_t    : one buffered instruction with its PC
package rv_fetch_pkg;

  localparam logic [31:0] DEFAULT_NOP_INST = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PC_INC           = 32'd4;
  localparam logic [31:0] PC_ALIGN_MASK    = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,  // single idle cycle after reset release
    S_RUN   = 2'd1,  // normal streaming
    S_DRAIN = 2'd2   // stale responses still owed by memory
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/if_prefetch_queue_if.sv
// Instruction-memory request/response bus.
//   req/addr   : fetch request and word address (fetch side drives)
//   gnt        : request accepted this cycle (memory drives)
//   rvalid     : in-order response valid (memory drives)
//   rdata      : response instruction word (memory drives)
// master = prefetch queue, slave = instruction memory.
interface if_prefetch_queue_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/sync_fifo.sv
// Small synchronous FIFO of fetch entries.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   push, wdata  : write one entry
//   pop, rdata   : consume the head entry; rdata is the head, combinational
//   flush        : empty the FIFO (takes priority over push/pop)
//   count        : number of stored entries (0..DEPTH)
//   empty, full  : status flags
module sync_fifo
  import rv_fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     push,
  input  fetch_entry_t             wdata,
  input  logic                     pop,
  output fetch_entry_t             rdata,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Pointers are exactly log2(DEPTH) bits, so they wrap on their own.
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: the storage array has no reset; an entry is only read after it has
  // been written, so clearing it would only cost reset fan-out.
  always_ff @(posedge i_clk) begin
    if (push && !flush) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);

endmodule

// File: rtl/if_prefetch_queue.sv
// Instruction prefetch front-end feeding the IF/ID buffer.
//   i_clk, i_rst   : clock, asynchronous active-high reset
//   imem           : instruction-memory bus (req/addr out, gnt/rvalid/rdata in)
//   i_redirect     : EX-stage taken branch / jump
//   i_redirect_pc  : redirect target (low two bits ignored)
//   i_id_stall     : ID buffer is holding; head entry must not be consumed
//   o_if_vld       : head entry valid
//   o_if_inst      : head instruction, NOP_INST when empty
//   o_if_pc        : head PC, 0 when empty
// Sequential requests are issued while buffered + outstanding fetches stay
// below DEPTH, so a returning response always has a FIFO slot. A redirect
// flushes the FIFO and marks every in-flight response as stale.
module if_prefetch_queue
  import rv_fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INST = DEFAULT_NOP_INST
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  if_prefetch_queue_if.master        imem,
  input  logic                       i_redirect,
  input  logic [31:0]                i_redirect_pc,
  input  logic                       i_id_stall,
  output logic                       o_if_vld,
  output logic [31:0]                o_if_inst,
  output logic [31:0]                o_if_pc
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] CREDIT_CAP = (CW + 1)'(DEPTH);

  fetch_state_t  state, state_next;
  logic [31:0]   fetch_pc, resp_pc, target_pc;
  logic [CW-1:0] outstanding, outstanding_next;
  logic [CW-1:0] discard, discard_next;
  logic [CW-1:0] count;
  logic [CW:0]   in_use;
  logic          fire, rsp, push, pop, empty, full;
  fetch_entry_t  push_entry, head;

  assign target_pc = i_redirect_pc & PC_ALIGN_MASK;

  // Request side: the credit check counts stale in-flight fetches too, since
  // they still return and occupy the response path.
  assign in_use    = {1'b0, count} + {1'b0, outstanding};
  assign imem.req  = (state != S_BOOT) && (in_use < CREDIT_CAP);
  assign imem.addr = fetch_pc;
  assign fire      = imem.req && imem.gnt;

  // A response with nothing outstanding (e.g. one owed from before a reset)
  // is ignored rather than allowed to underflow the counter.
  assign rsp              = imem.rvalid && (outstanding != '0);
  assign outstanding_next = outstanding + CW'(fire) - CW'(rsp);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    discard_next = discard;
    if (i_redirect)                   discard_next = outstanding_next;
    else if (rsp && discard != '0)    discard_next = discard - 1'b1;
  end

  assign state_next = (discard_next != '0) ? S_DRAIN : S_RUN;

  assign push = rsp && (discard == '0) && !i_redirect;
  assign pop  = !empty && !i_id_stall && !i_redirect;

  assign push_entry.inst = imem.rdata;
  assign push_entry.pc   = resp_pc;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= S_BOOT;
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      state       <= state_next;
      outstanding <= outstanding_next;
      discard     <= discard_next;
      if (i_redirect) begin
        fetch_pc <= target_pc;
        resp_pc  <= target_pc;
      end else begin
        if (fire) fetch_pc <= fetch_pc + PC_INC;
        if (push) resp_pc  <= resp_pc + PC_INC;
      end
    end
  end

  sync_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .push  (push),
    .wdata (push_entry),
    .pop   (pop),
    .rdata (head),
    .flush (i_redirect),
    .count (count),
    .empty (empty),
    .full  (full)
  );

  assign o_if_vld  = !empty;
  assign o_if_inst = empty ? NOP_INST : head.inst;
  assign o_if_pc   = empty ? 32'h0 : head.pc;

  a_no_overflow : assert property (@(posedge i_clk) disable iff (i_rst) !(push && full));
  a_rsp_owed    : assert property (@(posedge i_clk) disable iff (i_rst) imem.rvalid |-> (outstanding != '0));

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Randomized scoreboard bench for if_prefetch_queue. The reference model is
// the program stream itself: after reset or a redirect to T the delivered
// pairs must be T, T+4, T+8, ... with inst = memory word at that PC.
module tb_if_prefetch_queue;
  import rv_fetch_pkg::*;

  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [31:0] BOOT_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        if_vld;
  logic [31:0] if_inst, if_pc;

  if_prefetch_queue_if imem ();

  if_prefetch_queue #(.DEPTH(4), .RESET_PC(BOOT_PC), .NOP_INST(NOP)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .imem          (imem),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc),
    .i_id_stall    (stall),
    .o_if_vld      (if_vld),
    .o_if_inst     (if_inst),
    .o_if_pc       (if_pc)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  int n_deliv      = 0;
  int lat_min      = 1;
  int lat_max      = 1;
  int gnt_pct      = 100;
  bit scramble     = 1'b0;
  logic [31:0] exp_fa;

  typedef struct { int due; logic [31:0] data; } resp_t;
  resp_t        mem_q[$];
  fetch_entry_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return scramble ? ((a * 32'h9E37_79B1) ^ 32'h0BAD_F00D) : a;
  endfunction

  // Expected delivery stream starting at an aligned PC.
  task automatic refill(input logic [31:0] start);
    fetch_entry_t e;
    exp_q.delete();
    for (int i = 0; i < 256; i++) begin
      e.pc   = start + 32'(4 * i);
      e.inst = mem_word(e.pc);
      exp_q.push_back(e);
    end
  endtask

  // Instruction memory: random grants, in-order responses after a random
  // latency. Also tracks the address every grant should carry.
  logic        prev_wait;
  logic [31:0] prev_addr;
  always begin
    resp_t r;
    @(negedge clk); #1;
    if (rst) begin
      mem_q.delete();
      imem.gnt = 1'b0; imem.rvalid = 1'b0; imem.rdata = '0;
      prev_wait = 1'b0;
    end else begin
      cyc++;
      if (prev_wait && imem.req) check("addr_hold", imem.addr, prev_addr);
      imem.gnt = (int'($urandom_range(99)) < gnt_pct);
      if (imem.req && imem.gnt) begin
        check("imem_addr", imem.addr, exp_fa);
        r.due  = cyc + int'($urandom_range(lat_max, lat_min));
        r.data = mem_word(imem.addr);
        mem_q.push_back(r);
        exp_fa = exp_fa + 32'd4;
      end
      if (redirect) exp_fa = redirect_pc & 32'hFFFF_FFFC;
      prev_wait = imem.req && !imem.gnt && !redirect;
      prev_addr = imem.addr;
      if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
        imem.rvalid = 1'b1;
        imem.rdata  = mem_q[0].data;
        void'(mem_q.pop_front());
      end else begin
        imem.rvalid = 1'b0;
        imem.rdata  = $urandom;
      end
    end
  end

  // Monitor: compares each consumed head entry with the scoreboard.
  logic        held_v = 1'b0;
  logic [31:0] held_pc, held_inst;
  always begin
    fetch_entry_t e;
    @(negedge clk); #2;
    if (rst) begin
      held_v = 1'b0;
    end else begin
      if (held_v) begin
        check("stall_hold_vld", 32'(if_vld), 32'd1);
        check("stall_hold_pc", if_pc, held_pc);
        check("stall_hold_inst", if_inst, held_inst);
      end
      if (!if_vld) begin
        check("empty_inst", if_inst, NOP);
        check("empty_pc", if_pc, 32'h0);
      end else if (!redirect && !stall) begin
        if (exp_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL unexpected_delivery: got pc %h, nothing expected", if_pc);
        end else begin
          e = exp_q.pop_front();
          check("deliv_pc", if_pc, e.pc);
          check("deliv_inst", if_inst, e.inst);
        end
        n_deliv++;
      end
      held_v    = if_vld && stall && !redirect;
      held_pc   = if_pc;
      held_inst = if_inst;
    end
  end

  task automatic wait_deliv(input int n, input int budget, input string name);
    int target = n_deliv + n;
    int k = 0;
    while (n_deliv < target && k < budget) begin
      @(negedge clk); #3;
      k++;
    end
    check(name, 32'(n_deliv >= target), 32'd1);
  endtask

  // Reset, check reset outputs, release, and measure first-valid latency
  // with zero-wait memory.
  task automatic do_reset(input bit hold_stall);
    int k = 0;
    @(negedge clk);
    rst = 1'b1; redirect = 1'b0; stall = hold_stall;
    lat_min = 1; lat_max = 1; gnt_pct = 100; scramble = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_vld", 32'(if_vld), 32'd0);
    check("rst_inst", if_inst, NOP);
    check("rst_pc", if_pc, 32'h0);
    check("rst_req", 32'(imem.req), 32'd0);
    check("rst_addr", imem.addr, BOOT_PC);
    exp_fa = BOOT_PC;
    refill(BOOT_PC);
    rst = 1'b0;
    while (k < 20 && !if_vld) begin
      @(posedge clk); #1;
      k++;
    end
    check("first_vld_latency", 32'(k), 32'd3);
  endtask

  task automatic set_redirect(input logic [31:0] t, input bit scr);
    redirect    = 1'b1;
    redirect_pc = t;
    scramble    = scr;
    refill(t & 32'hFFFF_FFFC);
  endtask

  initial begin
    int base;
    logic [31:0] t;
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; stall = 1'b0;
    imem.gnt = 1'b0; imem.rvalid = 1'b0; imem.rdata = '0;
    exp_fa = BOOT_PC;

    // Zero-wait boot: one instruction per cycle once primed.
    do_reset(1'b0);
    base = n_deliv;
    repeat (8) @(negedge clk);
    #3;
    check("zero_wait_throughput", 32'(n_deliv - base), 32'd8);

    // Stall from boot: requests stop at the credit cap, head holds PC 0.
    do_reset(1'b1);
    repeat (8) @(negedge clk);
    check("stall_req_cap", 32'(imem.req), 32'd0);
    check("stall_head_vld", 32'(if_vld), 32'd1);
    check("stall_head_pc", if_pc, 32'h0);
    stall = 1'b0;
    base = n_deliv;
    repeat (3) @(negedge clk);
    #3;
    check("drain_b2b", 32'(n_deliv - base), 32'd4);

    // Latency 3, redirect with fetches in flight.
    lat_min = 3; lat_max = 3;
    repeat (10) @(negedge clk);
    set_redirect(32'h0000_0100, 1'b1);
    @(negedge clk);
    redirect = 1'b0;
    check("flush_vld", 32'(if_vld), 32'd0);
    wait_deliv(2, 40, "redirect_100_timeout");

    // Redirect coinciding with a grant and a response, then a second
    // redirect while the first is still draining.
    lat_min = 2; lat_max = 2;
    repeat (10) @(negedge clk);
    set_redirect(32'h0000_0200, 1'b1);
    #2;
    check("redir_cycle_gnt", 32'(imem.req && imem.gnt), 32'd1);
    check("redir_cycle_rvalid", 32'(imem.rvalid), 32'd1);
    @(negedge clk);
    set_redirect(32'h0000_0300, 1'b1);
    @(negedge clk);
    redirect = 1'b0;
    check("flush2_vld", 32'(if_vld), 32'd0);
    wait_deliv(3, 40, "redirect_300_timeout");

    // Reset mid-stream with work buffered and in flight.
    stall = 1'b1;
    repeat (4) @(negedge clk);
    do_reset(1'b0);
    wait_deliv(4, 20, "reboot_timeout");

    // Random traffic: latency, grant rate, stalls and redirects (some near
    // the top of the address space, some misaligned).
    for (int it = 0; it < 400; it++) begin
      @(negedge clk);
      if (it % 80 == 0) begin
        lat_min = 1;
        lat_max = int'($urandom_range(5, 1));
        gnt_pct = int'($urandom_range(100, 30));
      end
      stall    = ($urandom_range(99) < 30);
      redirect = 1'b0;
      if (it == 0 || $urandom_range(99) < 6) begin
        if ($urandom_range(3) == 0) t = 32'hFFFF_FFE0 | 32'($urandom_range(31));
        else                        t = $urandom;
        set_redirect(t, 1'b1);
      end
    end
    @(negedge clk);
    redirect = 1'b0; stall = 1'b0; gnt_pct = 100;
    wait_deliv(10, 100, "random_progress");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
